// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle sequencing controller:
// state, instruction type, opcode, PC-select and trap-cause codes.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    localparam logic [1:0] IT_R = 2'b00;
    localparam logic [1:0] IT_J = 2'b01;
    localparam logic [1:0] IT_I = 2'b10;
    localparam logic [1:0] IT_S = 2'b11;

    localparam logic [4:0] OP_LW     = 5'd2;
    localparam logic [4:0] OP_SW     = 5'd3;
    localparam logic [4:0] OP_BEQ    = 5'd4;
    localparam logic [4:0] OP_J      = 5'd0;
    localparam logic [4:0] OP_J_MAX  = 5'd1;
    localparam logic [4:0] OP_RS_MAX = 5'd3;
    localparam logic [4:0] OP_I_MAX  = 5'd4;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] TC_NONE    = 2'b00;
    localparam logic [1:0] TC_ILLEGAL = 2'b01;
    localparam logic [1:0] TC_IMEM    = 2'b10;
    localparam logic [1:0] TC_DMEM    = 2'b11;

    function automatic logic opcode_legal(input logic [1:0] it, input logic [4:0] op);
        case (it)
            IT_I:    return op <= OP_I_MAX;
            IT_J:    return op <= OP_J_MAX;
            default: return op <= OP_RS_MAX;
        endcase
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Wait-cycle counter shared by the FETCH and MEM ready waits; pulses expire
// on the TIMEOUT-th consecutive low-ready cycle. TIMEOUT=0 builds no counter.
module mc_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expire = 1'b0;
        end else begin : g_on
            localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

            logic [W-1:0] count_reg;

            always_ff @(posedge clk) begin
                if (rst || clr || expire)
                    count_reg <= '0;
                else if (en)
                    count_reg <= count_reg + W'(1);
            end

            assign expire = en && (count_reg == LAST);
        end
    endgenerate

endmodule

// File: rtl/multicycle_controller.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer with ready timeouts, traps and halt.
// Optional macro MULTICYCLE_CTRL_PERF_CNT_EN builds retire and stall counters.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       opcode,
    input  logic [1:0]       itype,
    input  logic             stop,
    input  logic             alu_zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_sel,
    output logic             regw,
    output logic             wb_sel,
    output logic [2:0]       state_o,
    output logic             halted,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retire_cnt
);

    state_t     state_reg, state_next;
    logic [1:0] trap_cause_reg, trap_cause_next;
    logic       wait_en, expire, retire;
    logic       is_lw, is_sw, is_beq;

    assign is_lw  = (itype == IT_I) && (opcode == OP_LW);
    assign is_sw  = (itype == IT_I) && (opcode == OP_SW);
    assign is_beq = (itype == IT_I) && (opcode == OP_BEQ);

    // Clearing whenever not waiting gives a fresh count on every FETCH/MEM entry.
    assign wait_en = ((state_reg == ST_FETCH) && !imem_ready) ||
                     ((state_reg == ST_MEM)   && !dmem_ready);

    mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (!wait_en),
        .en     (wait_en),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_FETCH;
            trap_cause_reg <= TC_NONE;
        end else begin
            state_reg      <= state_next;
            trap_cause_reg <= trap_cause_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        trap_cause_next = trap_cause_reg;
        retire          = 1'b0;
        imem_req        = 1'b0;
        dmem_req        = 1'b0;
        dmem_we         = 1'b0;
        ir_write        = 1'b0;
        pc_write        = 1'b0;
        pc_sel          = PC_PLUS4;
        regw            = 1'b0;
        wb_sel          = 1'b0;

        case (state_reg)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    pc_sel     = PC_PLUS4;
                    state_next = ST_DECODE;
                end else if (expire) begin
                    state_next      = ST_TRAP;
                    trap_cause_next = TC_IMEM;
                end
            end
            ST_DECODE: begin
                if (opcode_legal(itype, opcode)) begin
                    state_next = ST_EXEC;
                end else begin
                    state_next      = ST_TRAP;
                    trap_cause_next = TC_ILLEGAL;
                end
            end
            ST_EXEC: begin
                if (itype == IT_J) begin
                    pc_write = 1'b1;
                    pc_sel   = PC_JUMP;
                    retire   = 1'b1;
                end else if (is_beq) begin
                    pc_write = alu_zero;
                    pc_sel   = PC_BRANCH;
                    retire   = 1'b1;
                end else if (is_lw || is_sw) begin
                    state_next = ST_MEM;
                end else begin
                    state_next = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_sw;
                if (dmem_ready) begin
                    if (is_sw)
                        retire = 1'b1;
                    else
                        state_next = ST_WB;
                end else if (expire) begin
                    state_next      = ST_TRAP;
                    trap_cause_next = TC_DMEM;
                end
            end
            ST_WB: begin
                regw   = 1'b1;
                wb_sel = is_lw;
                retire = 1'b1;
            end
            default: ;
        endcase

        if (retire)
            state_next = stop ? ST_HALT : ST_FETCH;

        if (rst) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            ir_write = 1'b0;
            pc_write = 1'b0;
            pc_sel   = PC_PLUS4;
            regw     = 1'b0;
            wb_sel   = 1'b0;
        end
    end

    assign state_o    = state_reg;
    assign halted     = (state_reg == ST_HALT);
    assign trap       = (state_reg == ST_TRAP);
    assign trap_cause = trap_cause_reg;

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] retire_cnt_reg;
    logic [CNT_W-1:0] stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_reg <= '0;
            stall_cnt_reg  <= '0;
        end else begin
            if (retire)
                retire_cnt_reg <= retire_cnt_reg + CNT_W'(1);
            if (wait_en)
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

    assign retire_cnt = retire_cnt_reg;
`else
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: inputs driven just after each
// rising edge, outputs checked on the falling edge.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  opcode;
    logic [1:0]  itype;
    logic        stop;
    logic        alu_zero;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req, dmem_req, dmem_we, ir_write, pc_write;
    logic [1:0]  pc_sel;
    logic        regw, wb_sel;
    logic [2:0]  state_o;
    logic        halted, trap;
    logic [1:0]  trap_cause;
    logic [31:0] retire_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.TIMEOUT(16), .CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .itype      (itype),
        .stop       (stop),
        .alu_zero   (alu_zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_sel     (pc_sel),
        .regw       (regw),
        .wb_sel     (wb_sel),
        .state_o    (state_o),
        .halted     (halted),
        .trap       (trap),
        .trap_cause (trap_cause),
        .retire_cnt (retire_cnt)
    );

    // retire_cnt is only built with the perf-counter macro; otherwise it reads 0.
    function automatic logic [31:0] exp_ret(input int n);
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
        return 32'(n);
`else
        return 32'(0 * n);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic instr(input logic [1:0] it, input logic [4:0] op, input logic st);
        itype  = it;
        opcode = op;
        stop   = st;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        sample();
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_imem_req_forced", 32'(imem_req), 32'd0);
        chk("rst_retire", retire_cnt, 32'd0);
        chk("rst_trap_cause", 32'(trap_cause), 32'd0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; instr(2'b00, 5'd1, 1'b0);
        alu_zero = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
        do_reset();

        // R-type op 1: FETCH, DECODE, EXEC, WB, FETCH
        sample();
        chk("r_fetch_state", 32'(state_o), 32'd0);
        chk("r_fetch_imem_req", 32'(imem_req), 32'd1);
        chk("r_fetch_ir_write", 32'(ir_write), 32'd1);
        chk("r_fetch_pc_write", 32'(pc_write), 32'd1);
        chk("r_fetch_regw", 32'(regw), 32'd0);
        tick(); sample();
        chk("r_decode_state", 32'(state_o), 32'd1);
        chk("r_decode_regw", 32'(regw), 32'd0);
        tick(); sample();
        chk("r_exec_state", 32'(state_o), 32'd2);
        chk("r_exec_regw", 32'(regw), 32'd0);
        tick(); sample();
        chk("r_wb_state", 32'(state_o), 32'd4);
        chk("r_wb_regw", 32'(regw), 32'd1);
        chk("r_wb_sel", 32'(wb_sel), 32'd0);
        tick(); sample();
        chk("r_back_fetch", 32'(state_o), 32'd0);
        chk("r_retire", retire_cnt, exp_ret(1));

        // LW with dmem_ready low for 3 MEM cycles
        instr(2'b10, 5'd2, 1'b0);
        tick(); tick();
        dmem_ready = 1'b0;
        sample();
        chk("lw_exec_state", 32'(state_o), 32'd2);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) dmem_ready = 1'b1;
            sample();
            chk("lw_mem_state", 32'(state_o), 32'd3);
            chk("lw_mem_req", 32'(dmem_req), 32'd1);
            chk("lw_mem_we", 32'(dmem_we), 32'd0);
        end
        tick(); sample();
        chk("lw_wb_state", 32'(state_o), 32'd4);
        chk("lw_wb_regw", 32'(regw), 32'd1);
        chk("lw_wb_sel", 32'(wb_sel), 32'd1);
        tick(); sample();
        chk("lw_back_fetch", 32'(state_o), 32'd0);
        chk("lw_retire", retire_cnt, exp_ret(2));

        // BEQ taken, BEQ not taken, J
        instr(2'b10, 5'd4, 1'b0);
        tick(); tick();
        alu_zero = 1'b1;
        sample();
        chk("beq_t_state", 32'(state_o), 32'd2);
        chk("beq_t_pc_write", 32'(pc_write), 32'd1);
        chk("beq_t_pc_sel", 32'(pc_sel), 32'd1);
        tick(); sample();
        chk("beq_t_fetch", 32'(state_o), 32'd0);
        chk("beq_t_retire", retire_cnt, exp_ret(3));
        tick(); tick();
        alu_zero = 1'b0;
        sample();
        chk("beq_n_pc_write", 32'(pc_write), 32'd0);
        chk("beq_n_pc_sel", 32'(pc_sel), 32'd1);
        tick(); sample();
        chk("beq_n_fetch", 32'(state_o), 32'd0);
        instr(2'b01, 5'd1, 1'b0);
        tick(); tick(); sample();
        chk("j_pc_write", 32'(pc_write), 32'd1);
        chk("j_pc_sel", 32'(pc_sel), 32'd2);
        tick(); sample();
        chk("j_fetch", 32'(state_o), 32'd0);
        chk("j_retire", retire_cnt, exp_ret(5));

        // SW with stop set: halts after MEM
        instr(2'b10, 5'd3, 1'b1);
        tick(); tick(); tick(); sample();
        chk("sw_mem_state", 32'(state_o), 32'd3);
        chk("sw_mem_we", 32'(dmem_we), 32'd1);
        chk("sw_mem_req", 32'(dmem_req), 32'd1);
        tick(); sample();
        chk("sw_halt_state", 32'(state_o), 32'd5);
        chk("sw_halted", 32'(halted), 32'd1);
        chk("sw_retire", retire_cnt, exp_ret(6));
        for (int i = 0; i < 20; i++) begin
            tick(); sample();
            chk("halt_imem_req", 32'(imem_req), 32'd0);
        end
        chk("halt_sticky", 32'(state_o), 32'd5);

        // Illegal R op 7 traps after DECODE
        do_reset();
        instr(2'b00, 5'd7, 1'b0);
        tick(); tick(); sample();
        chk("ill_state", 32'(state_o), 32'd6);
        chk("ill_trap", 32'(trap), 32'd1);
        chk("ill_cause", 32'(trap_cause), 32'd1);
        chk("ill_retire", retire_cnt, 32'd0);

        // imem_ready held low: 16 FETCH cycles then TRAP cause 10
        do_reset();
        instr(2'b00, 5'd1, 1'b0);
        imem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sample();
            chk("ito_fetch_state", 32'(state_o), 32'd0);
            tick();
        end
        sample();
        chk("ito_state", 32'(state_o), 32'd6);
        chk("ito_trap", 32'(trap), 32'd1);
        chk("ito_cause", 32'(trap_cause), 32'd2);
        tick(); tick(); sample();
        chk("ito_imem_req", 32'(imem_req), 32'd0);
        chk("ito_cause_hold", 32'(trap_cause), 32'd2);

        // Ready arriving on the last allowed cycle wins over the timeout
        do_reset();
        for (int i = 0; i < 15; i++) tick();
        imem_ready = 1'b1;
        sample();
        chk("race_ir_write", 32'(ir_write), 32'd1);
        tick(); sample();
        chk("race_decode", 32'(state_o), 32'd1);

        // LW with dmem_ready held low: TRAP cause 11 after 16 MEM cycles
        do_reset();
        instr(2'b10, 5'd2, 1'b0);
        dmem_ready = 1'b0;
        tick(); tick();
        for (int i = 0; i < 16; i++) begin
            tick(); sample();
            chk("dto_mem_state", 32'(state_o), 32'd3);
        end
        tick(); sample();
        chk("dto_state", 32'(state_o), 32'd6);
        chk("dto_cause", 32'(trap_cause), 32'd3);

        // Reset in the middle of a MEM wait
        do_reset();
        tick(); tick(); tick(); tick(); sample();
        chk("mrst_in_mem", 32'(state_o), 32'd3);
        rst = 1'b1;
        sample();
        chk("mrst_dmem_req_forced", 32'(dmem_req), 32'd0);
        tick(); rst = 1'b0; sample();
        chk("mrst_state", 32'(state_o), 32'd0);
        chk("mrst_dmem_req", 32'(dmem_req), 32'd0);
        chk("mrst_retire", retire_cnt, 32'd0);
        chk("mrst_cause", 32'(trap_cause), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
